// File: rtl/ps_word_packer.sv
// PacketStream width up-converter: packs up to COUNT input words of one packet
// into a single COUNT*WIDTH output word, flushing short groups on eop.
module ps_word_packer #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4,
    parameter int CW    = $clog2(COUNT + 1)
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic [WIDTH-1:0]       i_dat,
    input  logic                   i_val,
    input  logic                   i_eop,
    output logic                   i_rdy,
    output logic [COUNT*WIDTH-1:0] o_dat,
    output logic [CW-1:0]          o_cnt,
    output logic                   o_val,
    output logic                   o_eop,
    input  logic                   o_rdy
);
    localparam int IW = $clog2(COUNT);
    localparam logic [IW-1:0] LAST = IW'(COUNT - 1);

    logic [COUNT-1:0][WIDTH-1:0] asm_q, asm_d, grp;
    logic [IW-1:0]               idx_q, idx_d;
    logic [COUNT*WIDTH-1:0]      dat_q, dat_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        val_q, val_d;
    logic                        eop_q, eop_d;
    logic                        in_xfer, done;

    assign i_rdy   = o_rdy | ~val_q;
    assign in_xfer = i_val & i_rdy;
    assign done    = in_xfer & ((idx_q == LAST) | i_eop);

    // Group as it will leave: earlier lanes from the assembly register,
    // the current word in lane idx, zeros above.
    always_comb begin
        grp = '0;
        for (int k = 0; k < COUNT; k++) begin
            if (IW'(k) < idx_q)
                grp[k] = asm_q[k];
            else if (IW'(k) == idx_q)
                grp[k] = i_dat;
        end
    end

    always_comb begin
        asm_d = asm_q;
        idx_d = idx_q;
        dat_d = dat_q;
        cnt_d = cnt_q;
        val_d = val_q;
        eop_d = eop_q;
        if (done) begin
            asm_d = '0;
            idx_d = '0;
            dat_d = grp;
            cnt_d = CW'(idx_q) + CW'(1);
            eop_d = i_eop;
            val_d = 1'b1;
        end else begin
            if (in_xfer) begin
                asm_d[idx_q] = i_dat;
                idx_d        = idx_q + IW'(1);
            end
            if (val_q & o_rdy)
                val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q <= '0;
            idx_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
            val_q <= 1'b0;
            eop_q <= 1'b0;
        end else begin
            asm_q <= asm_d;
            idx_q <= idx_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
            val_q <= val_d;
            eop_q <= eop_d;
        end
    end

    assign o_dat = dat_q;
    assign o_cnt = cnt_q;
    assign o_val = val_q;
    assign o_eop = eop_q;
endmodule

// File: tb/tb_ps_word_packer.sv
// Directed bench for ps_word_packer (WIDTH=8, COUNT=4): timing, packing,
// backpressure, same-edge replace and reset discard.
module tb_ps_word_packer;
    logic        reset, clk;
    logic [7:0]  i_dat;
    logic        i_val, i_eop, i_rdy;
    logic [31:0] o_dat;
    logic [2:0]  o_cnt;
    logic        o_val, o_eop, o_rdy;

    int checks = 0;
    int errors = 0;
    logic [35:0] outq[$];

    ps_word_packer #(.WIDTH(8), .COUNT(4)) dut (
        .reset(reset), .clk(clk),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_cnt(o_cnt), .o_val(o_val), .o_eop(o_eop),
        .o_rdy(o_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output transfer, sampled mid-cycle.
    always @(negedge clk)
        if (!reset && o_val && o_rdy)
            outq.push_back({o_eop, o_cnt, o_dat});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        int   n;
        logic acc;
        i_val = 1'b1; i_dat = d; i_eop = e; n = 0;
        do begin
            @(negedge clk); acc = i_rdy;
            @(posedge clk); #1; n++;
        end while (!acc && n < 100);
        if (!acc) chk("send_timeout", 0, 1);
        i_val = 1'b0; i_eop = 1'b0;
    endtask

    task automatic idle(input int n);
        i_val = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic [2:0] c, input logic e);
        logic [35:0] r;
        if (outq.size() == 0) begin
            chk({tag, "_present"}, 0, 1);
        end else begin
            r = outq.pop_front();
            chk({tag, "_dat"}, r[31:0], d);
            chk({tag, "_cnt"}, r[34:32], c);
            chk({tag, "_eop"}, r[35], e);
        end
    endtask

    initial begin
        // Reset held with a valid input present and downstream stalled
        reset = 1'b1; i_val = 1'b1; i_dat = 8'h55; i_eop = 1'b0; o_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_val", o_val, 0);
        chk("rst_o_dat", o_dat, 0);
        chk("rst_o_cnt", o_cnt, 0);
        chk("rst_o_eop", o_eop, 0);
        chk("rst_i_rdy", i_rdy, 1);
        i_val = 1'b0;
        @(negedge clk) reset = 1'b0;
        o_rdy = 1'b1;
        idle(1);

        // 8-word packet, back-to-back
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), i == 8);
            if (i == 4) begin
                chk("p8_g0_val", o_val, 1);
                chk("p8_g0_dat", o_dat, 32'h04030201);
            end else if (i == 8) begin
                chk("p8_g1_val", o_val, 1);
                chk("p8_g1_dat", o_dat, 32'h08070605);
                chk("p8_g1_eop", o_eop, 1);
            end else begin
                chk("p8_gap_val", o_val, 0);
            end
        end
        idle(1);
        chk("p8_drain_val", o_val, 0);
        expect_out("p8_o0", 32'h04030201, 3'd4, 1'b0);
        expect_out("p8_o1", 32'h08070605, 3'd4, 1'b1);
        chk("p8_count", outq.size(), 0);

        // 6-word packet followed by a 1-word packet
        for (int i = 0; i < 6; i++) send(8'h11 + 8'(i), i == 5);
        send(8'hAA, 1'b1);
        chk("p1_val", o_val, 1);
        idle(2);
        expect_out("p6_o0", 32'h14131211, 3'd4, 1'b0);
        expect_out("p6_o1", 32'h00001615, 3'd2, 1'b1);
        expect_out("p1_o0", 32'h000000AA, 3'd1, 1'b1);
        chk("p6_count", outq.size(), 0);

        // Backpressure while the source keeps offering words
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'h31 + 8'(i), i == 7);
            end
            begin
                int n = 0;
                do begin @(posedge clk); #1; n++; end while (!o_val && n < 50);
                chk("bp_wait", o_val, 1);
                o_rdy = 1'b0;
                repeat (4) begin
                    @(posedge clk); #1;
                    chk("bp_i_rdy", i_rdy, 0);
                    chk("bp_o_val", o_val, 1);
                    chk("bp_o_dat", o_dat, 32'h34333231);
                end
                o_rdy = 1'b1;
            end
        join
        idle(2);
        expect_out("bp_o0", 32'h34333231, 3'd4, 1'b0);
        expect_out("bp_o1", 32'h38373635, 3'd4, 1'b1);
        chk("bp_count", outq.size(), 0);

        // Single-word packets: each drains on the edge the next one loads
        send(8'hB1, 1'b1);
        chk("se_val0", o_val, 1);
        send(8'hB2, 1'b1);
        chk("se_val1", o_val, 1);
        chk("se_dat1", o_dat, 32'h000000B2);
        send(8'hB3, 1'b1);
        chk("se_val2", o_val, 1);
        chk("se_dat2", o_dat, 32'h000000B3);
        idle(2);
        expect_out("se_o0", 32'h000000B1, 3'd1, 1'b1);
        expect_out("se_o1", 32'h000000B2, 3'd1, 1'b1);
        expect_out("se_o2", 32'h000000B3, 3'd1, 1'b1);
        chk("se_count", outq.size(), 0);

        // Reset drops a pending output word (async, mid-cycle)
        o_rdy = 1'b0;
        send(8'h61, 1'b1);
        chk("rp_pending", o_val, 1);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("rp_o_val", o_val, 0);
        chk("rp_o_dat", o_dat, 0);
        chk("rp_i_rdy", i_rdy, 1);
        @(negedge clk) reset = 1'b0;
        o_rdy = 1'b1;

        // Reset after 3 words of a group, then a fresh packet
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        idle(1);
        chk("rm_o_val", o_val, 0);
        for (int i = 0; i < 4; i++) send(8'h21 + 8'(i), i == 3);
        idle(2);
        expect_out("rm_o0", 32'h24232221, 3'd4, 1'b1);
        chk("rm_count", outq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps_word_packer.md
Name: ps_word_packer

Overview:
- Width up-converter for the PacketStream interface; packs up to COUNT consecutive WIDTH-bit words of one packet into a single COUNT*WIDTH-bit output word.
- Sits directly upstream of the one-register PacketStream buffer and feeds wide-bus consumers: DMA, wide FIFOs.
- Packet boundaries are preserved. A short final group is flushed on eop and tagged with a word count.

Parameters:
- WIDTH, 8: input word width, bits; must be ≥1.
- COUNT, 4: input words per output word; must be ≥2.
- CW, $clog2(COUNT+1): width of o_cnt; derived, must not be overridden.

Ports:
- reset  input  1  asynchronous reset, active high
- clk  input  1  clock; all logic on rising edge
- i_dat  input  WIDTH  input data word
- i_val  input  1  input word valid
- i_eop  input  1  input word is last word of packet
- i_rdy  output  1  input ready
- o_dat  output  COUNT*WIDTH  packed word; input word k of a group at bits [k*WIDTH +: WIDTH], k=0 first received
- o_cnt  output  CW  number of valid words in o_dat, 1..COUNT
- o_val  output  1  output valid
- o_eop  output  1  output word contains last word of packet
- o_rdy  input  1  output ready

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high; all registers are cleared on posedge reset regardless of clk.
- Reset values:
  - o_dat = 0, o_cnt = 0, o_val = 0, o_eop = 0.
  - Internal assembly register = 0, lane index idx = 0.
  - i_rdy = 1 immediately after reset.
- Handshakes:
  - Input transfer: i_val & i_rdy on a rising edge.
  - Output transfer: o_val & o_rdy on a rising edge.
- i_rdy = o_rdy | ~o_val, purely combinational from o_rdy and the o_val register. No path from i_val/i_eop to i_rdy.
- On each input transfer:
  - i_dat is written to lane idx of the assembly register.
  - Completing word: idx == COUNT-1 or i_eop = 1.
  - Non-completing word: idx increments.
  - Completing word, same edge:
    - Output register loads the assembly contents including the new word.
    - Lanes above idx load zero.
    - o_cnt = idx+1, o_eop = i_eop, o_val = 1.
    - Assembly register clears to 0; idx returns to 0.
- Output register update when no completing transfer occurs:
  - If o_val & o_rdy: o_val clears to 0; o_dat/o_cnt/o_eop hold their values.
  - Otherwise all output registers hold.
- Latency: a group appears on the output one cycle after its completing word is accepted.
- Throughput: one input word per cycle while o_rdy = 1, i.e. one output word per COUNT input cycles.
- Simultaneous events:
  - An output transfer and a completing input transfer on the same edge: the new group replaces the old one and o_val stays 1, with no bubble.
  - o_val = 1 and o_rdy = 0: i_rdy = 0. Input stalls and the partial group holds.
- Backpressure does not change data: o_dat/o_cnt/o_eop stay stable while o_val & ~o_rdy.
- i_dat, i_eop are ignored when i_val = 0. No transfer occurs while i_rdy = 0 even if i_val = 1.
- A packet of exactly COUNT*n words produces n outputs; only the last has o_eop = 1 and o_cnt = COUNT.
- A one-word packet produces one output: o_cnt = 1, o_eop = 1, upper lanes 0.
- Reset mid-packet discards the partial group and any pending output word. No output is emitted for it.
- idx never exceeds COUNT-1.

Test Plan:
- Settings: WIDTH=8, COUNT=4, o_rdy=1 unless stated.
- Reset: hold reset 3 cycles with i_val=1 -> o_val=0, o_dat=0, o_cnt=0, o_eop=0, i_rdy=1; release -> first word lands in lane 0.
- 8-word packet 0x01..0x08, eop on 0x08, back-to-back -> o_dat=0x04030201 (cnt 4, eop 0) then 0x08070605 (cnt 4, eop 1); o_val for exactly 2 cycles; each output 1 cycle after its 4th input.
- 6-word packet 0x11..0x16 then 1-word packet 0xAA -> 0x14131211 (cnt 4, eop 0), 0x00001615 (cnt 2, eop 1), 0x000000AA (cnt 1, eop 1); no lane carries over between packets.
- Backpressure: o_rdy=0 once the first group is valid; source keeps i_val=1 -> i_rdy=0, o_dat stable, no word lost or duplicated; o_rdy=1 -> stream resumes and the sequence matches the no-stall case.
- Same-edge replace: o_rdy=1 with a completing word accepted in the cycle a group drains -> o_val stays 1 with no bubble, next group correct.
- Reset after 3 words of a group -> no output; next packet 0x21..0x24 -> 0x24232221 (cnt 4).
